// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - fetch/decode/execute control FSM for the 8-bit accumulator processor
// Optional SINGLE_STEP_EN adds a step input and a STEPWAIT state between instructions.
module control_fsm #(
  parameter int SYNC_STAGES = 2,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [2:0]         IR75,
  input  logic               Aeq0,
  input  logic               Apos,
  input  logic               enter,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               IRload,
  output logic               JMPmux,
  output logic               PCload,
  output logic               Meminst,
  output logic               MemWr,
  output logic [1:0]         Asel,
  output logic               Aload,
  output logic               Sub,
  output logic               halt,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] S_START    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_LOAD     = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_STORE    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_ADD      = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_SUB      = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_INPUT    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_JZ       = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JPOS     = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_HALT     = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_STEPWAIT = STATE_W'(11);

`ifdef SINGLE_STEP_EN
  localparam logic [STATE_W-1:0] S_DONE = S_STEPWAIT;
`else
  localparam logic [STATE_W-1:0] S_DONE = S_FETCH;
`endif

  logic [STATE_W-1:0]     state_q;
  logic [STATE_W-1:0]     state_nx;
  logic [SYNC_STAGES-1:0] enter_sync;
  logic                   enter_d;
  logic                   enter_rise;

  // Edge register holds the previous synchronised level so a key already down is ignored.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      enter_sync <= '0;
      enter_d    <= 1'b0;
    end else begin
      enter_sync[0] <= enter;
      for (int i = 1; i < SYNC_STAGES; i++) enter_sync[i] <= enter_sync[i-1];
      enter_d <= enter_sync[SYNC_STAGES-1];
    end
  end

  assign enter_rise = enter_sync[SYNC_STAGES-1] & ~enter_d;

`ifdef SINGLE_STEP_EN
  logic [SYNC_STAGES-1:0] step_sync;
  logic                   step_d;
  logic                   step_rise;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      step_sync <= '0;
      step_d    <= 1'b0;
    end else begin
      step_sync[0] <= step;
      for (int i = 1; i < SYNC_STAGES; i++) step_sync[i] <= step_sync[i-1];
      step_d <= step_sync[SYNC_STAGES-1];
    end
  end

  assign step_rise = step_sync[SYNC_STAGES-1] & ~step_d;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= S_START;
    else       state_q <= state_nx;
  end

  always_comb begin
    state_nx = S_START;
    case (state_q)
      S_START:  state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (IR75)
          3'b000: state_nx = S_LOAD;
          3'b001: state_nx = S_STORE;
          3'b010: state_nx = S_ADD;
          3'b011: state_nx = S_SUB;
          3'b100: state_nx = S_INPUT;
          3'b101: state_nx = S_JZ;
          3'b110: state_nx = S_JPOS;
          3'b111: state_nx = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state_nx = S_DONE;
      S_INPUT:  state_nx = enter_rise ? S_DONE : S_INPUT;
      S_HALT:   state_nx = S_HALT;
`ifdef SINGLE_STEP_EN
      S_STEPWAIT: state_nx = step_rise ? S_FETCH : S_STEPWAIT;
`endif
      default:  state_nx = S_START;
    endcase
  end

  // Outputs are forced low while clear is held, even though START itself drives Aload.
  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = 2'b00;
    Aload   = 1'b0;
    Sub     = 1'b0;
    halt    = 1'b0;
    if (!clear) begin
      case (state_q)
        S_START: begin
          Asel  = 2'b11;
          Aload = 1'b1;
        end
        S_FETCH: begin
          IRload = 1'b1;
          PCload = 1'b1;
        end
        S_DECODE: Meminst = 1'b1;
        S_LOAD: begin
          Meminst = 1'b1;
          Asel    = 2'b10;
          Aload   = 1'b1;
        end
        S_STORE: begin
          Meminst = 1'b1;
          MemWr   = 1'b1;
        end
        S_ADD: begin
          Meminst = 1'b1;
          Aload   = 1'b1;
        end
        S_SUB: begin
          Meminst = 1'b1;
          Sub     = 1'b1;
          Aload   = 1'b1;
        end
        S_INPUT: begin
          if (enter_rise) begin
            Asel  = 2'b01;
            Aload = 1'b1;
          end
        end
        S_JZ: begin
          JMPmux = Aeq0;
          PCload = Aeq0;
        end
        S_JPOS: begin
          JMPmux = Apos;
          PCload = Apos;
        end
        S_HALT: halt = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - scoreboard bench for control_fsm
// Each queue entry carries the inputs for one cycle and the outputs expected in that cycle.
module tb_control_fsm;

  localparam int SYNC_STAGES = 2;
  localparam int STATE_W     = 4;

  // {state, IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, halt}
  localparam logic [13:0] E_RST   = 14'b0;
  localparam logic [13:0] E_START = {4'd0,  10'b00000_11_1_0_0};
  localparam logic [13:0] E_FETCH = {4'd1,  10'b10100_00_0_0_0};
  localparam logic [13:0] E_DEC   = {4'd2,  10'b00010_00_0_0_0};
  localparam logic [13:0] E_LOAD  = {4'd3,  10'b00010_10_1_0_0};
  localparam logic [13:0] E_STORE = {4'd4,  10'b00011_00_0_0_0};
  localparam logic [13:0] E_ADD   = {4'd5,  10'b00010_00_1_0_0};
  localparam logic [13:0] E_SUB   = {4'd6,  10'b00010_00_1_1_0};
  localparam logic [13:0] E_INW   = {4'd7,  10'b00000_00_0_0_0};
  localparam logic [13:0] E_INGO  = {4'd7,  10'b00000_01_1_0_0};
  localparam logic [13:0] E_JZT   = {4'd8,  10'b01100_00_0_0_0};
  localparam logic [13:0] E_JZN   = {4'd8,  10'b00000_00_0_0_0};
  localparam logic [13:0] E_JPT   = {4'd9,  10'b01100_00_0_0_0};
  localparam logic [13:0] E_JPN   = {4'd9,  10'b00000_00_0_0_0};
  localparam logic [13:0] E_HALT  = {4'd10, 10'b00000_00_0_0_1};
  localparam logic [13:0] E_SWAIT = {4'd11, 10'b00000_00_0_0_0};

  typedef struct packed {
    logic [2:0]  ir;
    logic        aeq0;
    logic        apos;
    logic        en;
    logic        st;
    logic [13:0] exp;
  } ent_t;

  logic clk = 1'b0;
  logic clear = 1'b0;
  logic [2:0] IR75 = 3'b000;
  logic Aeq0 = 1'b0;
  logic Apos = 1'b0;
  logic enter = 1'b0;
`ifdef SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  logic IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, halt;
  logic [1:0] Asel;
  logic [STATE_W-1:0] state;
  logic [13:0] obs;

  ent_t sb[$];
  ent_t cur;
  int n_checks = 0;
  int n_err = 0;

  control_fsm #(.SYNC_STAGES(SYNC_STAGES), .STATE_W(STATE_W)) dut (
    .clk(clk), .clear(clear), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos), .enter(enter),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr),
    .Asel(Asel), .Aload(Aload), .Sub(Sub), .halt(halt), .state(state)
  );

  assign obs = {state, IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, halt};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  function automatic void push(input logic [2:0] ir, input logic a0, input logic ap,
                               input logic en, input logic st, input logic [13:0] e);
    ent_t t;
    t.ir = ir; t.aeq0 = a0; t.apos = ap; t.en = en; t.st = st; t.exp = e;
    sb.push_back(t);
  endfunction

  task automatic do_reset;
    @(posedge clk); #1 clear = 1'b1;
    #1 clear = 1'b0;
  endtask

  task automatic test_reset;
    #1 clear = 1'b1;
    #1; n_checks++;
    if (obs !== E_RST) begin n_err++; $display("FAIL reset_hold: got %h want %h", obs, E_RST); end
    @(posedge clk); #1 clear = 1'b0;
    #1; n_checks++;
    if (obs !== E_START) begin n_err++; $display("FAIL reset_start: got %h want %h", obs, E_START); end
    @(posedge clk); #2; n_checks++;
    if (obs !== E_FETCH) begin n_err++; $display("FAIL reset_fetch: got %h want %h", obs, E_FETCH); end
    #1 clear = 1'b1;
    #1; n_checks++;
    if (obs !== E_RST) begin n_err++; $display("FAIL reset_mid_fetch: got %h want %h", obs, E_RST); end
    @(posedge clk); #1 clear = 1'b0;
    #1; n_checks++;
    if (obs !== E_START) begin n_err++; $display("FAIL reset_restart: got %h want %h", obs, E_START); end
    @(posedge clk); #2; n_checks++;
    if (obs !== E_FETCH) begin n_err++; $display("FAIL reset_refetch: got %h want %h", obs, E_FETCH); end
  endtask

  task automatic test_alu_mem;
    int k = 0;
    do_reset();
    push(3'd0, 0, 0, 0, 0, E_FETCH); push(3'd0, 0, 0, 0, 0, E_DEC); push(3'd0, 0, 0, 0, 0, E_LOAD);
    push(3'd2, 0, 0, 0, 0, E_FETCH); push(3'd2, 0, 0, 0, 0, E_DEC); push(3'd2, 0, 0, 0, 0, E_ADD);
    push(3'd1, 1, 1, 0, 0, E_FETCH); push(3'd1, 1, 1, 0, 0, E_DEC); push(3'd1, 1, 1, 0, 0, E_STORE);
    push(3'd3, 0, 0, 0, 0, E_FETCH); push(3'd3, 0, 0, 0, 0, E_DEC); push(3'd3, 0, 0, 0, 0, E_SUB);
    push(3'd0, 0, 0, 0, 0, E_FETCH);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      @(posedge clk); #1;
      IR75 = cur.ir; Aeq0 = cur.aeq0; Apos = cur.apos; enter = cur.en;
      #1; n_checks++;
      if (obs !== cur.exp) begin n_err++; $display("FAIL alu_mem cyc %0d: got %h want %h", k, obs, cur.exp); end
      k++;
    end
  endtask

  task automatic test_branches;
    int k = 0;
    do_reset();
    push(3'd5, 0, 0, 0, 0, E_FETCH); push(3'd5, 0, 0, 0, 0, E_DEC); push(3'd5, 1, 0, 0, 0, E_JZT);
    push(3'd5, 1, 1, 0, 0, E_FETCH); push(3'd5, 1, 1, 0, 0, E_DEC); push(3'd5, 0, 1, 0, 0, E_JZN);
    push(3'd6, 1, 0, 0, 0, E_FETCH); push(3'd6, 1, 0, 0, 0, E_DEC); push(3'd6, 1, 1, 0, 0, E_JPT);
    push(3'd6, 0, 1, 0, 0, E_FETCH); push(3'd6, 0, 1, 0, 0, E_DEC); push(3'd6, 1, 0, 0, 0, E_JPN);
    push(3'd0, 0, 0, 0, 0, E_FETCH);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      @(posedge clk); #1;
      IR75 = cur.ir; Aeq0 = cur.aeq0; Apos = cur.apos; enter = cur.en;
      #1; n_checks++;
      if (obs !== cur.exp) begin n_err++; $display("FAIL branches cyc %0d: got %h want %h", k, obs, cur.exp); end
      k++;
    end
  endtask

  task automatic test_input;
    int k = 0;
    enter = 1'b1;
    do_reset();
    push(3'd0, 0, 0, 1, 0, E_FETCH); push(3'd0, 0, 0, 1, 0, E_DEC); push(3'd0, 0, 0, 1, 0, E_LOAD);
    push(3'd4, 0, 0, 1, 0, E_FETCH); push(3'd4, 0, 0, 1, 0, E_DEC);
    for (int i = 0; i < 3; i++) push(3'd4, 0, 0, 1, 0, E_INW);
    for (int i = 0; i < SYNC_STAGES + 1; i++) push(3'd4, 0, 0, 0, 0, E_INW);
    for (int i = 0; i < SYNC_STAGES; i++) push(3'd4, 0, 0, 1, 0, E_INW);
    push(3'd4, 0, 0, 1, 0, E_INGO);
    push(3'd4, 0, 0, 1, 0, E_FETCH);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      @(posedge clk); #1;
      IR75 = cur.ir; Aeq0 = cur.aeq0; Apos = cur.apos; enter = cur.en;
      #1; n_checks++;
      if (obs !== cur.exp) begin n_err++; $display("FAIL input cyc %0d: got %h want %h", k, obs, cur.exp); end
      k++;
    end
    enter = 1'b0;
  endtask

  task automatic test_halt;
    int k = 0;
    do_reset();
    push(3'd7, 0, 0, 0, 0, E_FETCH); push(3'd7, 0, 0, 0, 0, E_DEC);
    for (int i = 0; i < 20; i++)
      push(3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, E_HALT);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      @(posedge clk); #1;
      IR75 = cur.ir; Aeq0 = cur.aeq0; Apos = cur.apos; enter = cur.en;
      #1; n_checks++;
      if (obs !== cur.exp) begin n_err++; $display("FAIL halt cyc %0d: got %h want %h", k, obs, cur.exp); end
      k++;
    end
    enter = 1'b0;
    @(posedge clk); #1 clear = 1'b1;
    #1; n_checks++;
    if (obs !== E_RST) begin n_err++; $display("FAIL halt_clear: got %h want %h", obs, E_RST); end
    #1 clear = 1'b0;
    #1; n_checks++;
    if (obs !== E_START) begin n_err++; $display("FAIL halt_restart: got %h want %h", obs, E_START); end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step;
    int k = 0;
    do_reset();
    push(3'd1, 0, 0, 0, 0, E_FETCH); push(3'd1, 0, 0, 0, 0, E_DEC); push(3'd1, 0, 0, 0, 0, E_STORE);
    for (int i = 0; i < 4; i++) push(3'd1, 0, 0, 0, 0, E_SWAIT);
    for (int i = 0; i < SYNC_STAGES + 1; i++) push(3'd1, 0, 0, 0, 1, E_SWAIT);
    push(3'd1, 0, 0, 0, 1, E_FETCH);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      @(posedge clk); #1;
      IR75 = cur.ir; Aeq0 = cur.aeq0; Apos = cur.apos; enter = cur.en; step = cur.st;
      #1; n_checks++;
      if (obs !== cur.exp) begin n_err++; $display("FAIL step cyc %0d: got %h want %h", k, obs, cur.exp); end
      k++;
    end
    step = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef SINGLE_STEP_EN
    test_single_step();
`else
    test_alu_mem();
    test_branches();
    test_input();
`endif
    test_halt();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
